ternary_mvm_ctrl: RTL and testbench

- Sequencer and weight store for the 16x8 ternary matrix-vector multiplier.
- Loads the ternary weight matrix from a byte stream into a local register array and drives the multiplier's flat weight bus.
- Streams input vectors to the multiplier two elements per enabled cycle, zero-flushes the pipeline after the last vector, and tags each multiplier output element with valid/index/last.
- Sits between the chip I/O shim and the multiplier.

---
 rtl/tmvm_pkg.sv | 32 +++
 rtl/ternary_mvm_ctrl_if.sv | 43 ++++
 rtl/tmvm_wload.sv | 54 +++++
 rtl/ternary_mvm_ctrl.sv | 117 +++++++++++
 tb/tb_ternary_mvm_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmvm_pkg.sv
// Shared types and constants for the ternary matrix-vector multiplier controller.
package tmvm_pkg;

    localparam int unsigned DEF_IN_LEN    = 16;
    localparam int unsigned DEF_OUT_LEN   = 8;
    localparam int unsigned DEF_BIT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;
    localparam logic [1:0] W_ILL  = 2'b10;

    function automatic int unsigned wbytes(input int unsigned in_len, input int unsigned out_len);
        return (2 * in_len * out_len) / 8;
    endfunction

    localparam int unsigned WBYTES = wbytes(DEF_IN_LEN, DEF_OUT_LEN);

    // Illegal codes are stored as zero weights.
    function automatic logic [1:0] sanitize(input logic [1:0] code);
        return (code == W_ILL) ? W_ZERO : code;
    endfunction

endpackage

// File: rtl/ternary_mvm_ctrl_if.sv
// Bundle of I/O-shim and multiplier-side signals around the ternary MVM controller.
interface ternary_mvm_ctrl_if #(
    parameter int unsigned IN_LEN    = 16,
    parameter int unsigned OUT_LEN   = 8,
    parameter int unsigned BIT_WIDTH = 8
);
    localparam int unsigned IDX_W = $clog2(OUT_LEN);
    localparam int unsigned W_W   = 2 * IN_LEN * OUT_LEN;

    logic                   load_i;
    logic [7:0]             wbyte_i;
    logic                   wbyte_valid_i;
    logic                   wbyte_ready_o;
    logic [2*BIT_WIDTH-1:0] x_i;
    logic                   x_valid_i;
    logic                   x_last_i;
    logic                   x_ready_o;
    logic                   mult_rst_n_o;
    logic                   mult_en_o;
    logic [2*BIT_WIDTH-1:0] mult_x_o;
    logic [W_W-1:0]         mult_w_o;
    logic [BIT_WIDTH-1:0]   mult_y_i;
    logic [BIT_WIDTH-1:0]   y_o;
    logic                   y_valid_o;
    logic [IDX_W-1:0]       y_idx_o;
    logic                   y_last_o;
    logic                   w_loaded_o;
    logic                   w_err_o;
    logic                   busy_o;

    modport slave (
        input  load_i, wbyte_i, wbyte_valid_i, x_i, x_valid_i, x_last_i, mult_y_i,
        output wbyte_ready_o, x_ready_o, mult_rst_n_o, mult_en_o, mult_x_o, mult_w_o,
               y_o, y_valid_o, y_idx_o, y_last_o, w_loaded_o, w_err_o, busy_o
    );

    modport master (
        output load_i, wbyte_i, wbyte_valid_i, x_i, x_valid_i, x_last_i, mult_y_i,
        input  wbyte_ready_o, x_ready_o, mult_rst_n_o, mult_en_o, mult_x_o, mult_w_o,
               y_o, y_valid_o, y_idx_o, y_last_o, w_loaded_o, w_err_o, busy_o
    );

endinterface

// File: rtl/tmvm_wload.sv
// Weight byte unpacker: four 2-bit codes per byte, LSB-first, into the flat weight register array.
module tmvm_wload
    import tmvm_pkg::*;
#(
    parameter int unsigned IN_LEN  = DEF_IN_LEN,
    parameter int unsigned OUT_LEN = DEF_OUT_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        wr_en,
    input  logic [7:0]                  wbyte,
    output logic [2*IN_LEN*OUT_LEN-1:0] w,
    output logic                        loaded,
    output logic                        err,
    output logic                        byte_last_c
);
    localparam int unsigned NBYTES = wbytes(IN_LEN, OUT_LEN);
    localparam int unsigned CNT_W  = $clog2(NBYTES);

    logic [CNT_W-1:0] cnt;
    logic             ill_c;

    assign byte_last_c = wr_en && (cnt == CNT_W'(NBYTES - 1));

    always_comb begin
        ill_c = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (wbyte[{2'(j), 1'b0} +: 2] == W_ILL) ill_c = 1'b1;
        end
    end

    // Byte k lands at weights 4k..4k+3, i.e. bit offset {k, j, 0}.
    always_ff @(posedge clk) begin
        if (rst) begin
            w      <= '0;
            cnt    <= '0;
            loaded <= 1'b0;
            err    <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            loaded <= 1'b0;
            err    <= 1'b0;
        end else if (wr_en) begin
            for (int j = 0; j < 4; j++) begin
                w[{cnt, 2'(j), 1'b0} +: 2] <= sanitize(wbyte[{2'(j), 1'b0} +: 2]);
            end
            if (ill_c)       err    <= 1'b1;
            if (byte_last_c) loaded <= 1'b1;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ternary_mvm_ctrl.sv
// Sequencer for the ternary MVM: weight load, pairwise input streaming, zero-flush drain and output tagging.
module ternary_mvm_ctrl
    import tmvm_pkg::*;
#(
    parameter int unsigned IN_LEN    = DEF_IN_LEN,
    parameter int unsigned OUT_LEN   = DEF_OUT_LEN,
    parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    ternary_mvm_ctrl_if.slave  bus
);
    localparam int unsigned    PH_W    = $clog2(OUT_LEN);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OUT_LEN - 1);

    state_t                     state;
    state_t                     state_nx;
    logic [PH_W-1:0]            phase;
    logic                       pending;
    logic                       clear_c;
    logic                       wr_en_c;
    logic                       x_ready_c;
    logic                       accept_c;
    logic                       en_c;
    logic                       byte_last_c;
    logic [2*IN_LEN*OUT_LEN-1:0] w;
    logic                       loaded;
    logic                       err;

    tmvm_wload #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) u_wload (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_c),
        .wr_en       (wr_en_c),
        .wbyte       (bus.wbyte_i),
        .w           (w),
        .loaded      (loaded),
        .err         (err),
        .byte_last_c (byte_last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A load request in IDLE takes priority over an arriving input pair.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.load_i)    state_nx = CLEAR;
                else if (accept_c) state_nx = RUN;
            end
            CLEAR: state_nx = LOAD;
            LOAD:  if (byte_last_c) state_nx = IDLE;
            RUN:   if (accept_c && bus.x_last_i && (phase == PH_LAST)) state_nx = DRAIN;
            DRAIN: if (phase == PH_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        x_ready_c = 1'b0;
        clear_c   = 1'b0;
        wr_en_c   = 1'b0;
        case (state)
            IDLE:    x_ready_c = loaded && !bus.load_i;
            CLEAR:   clear_c   = 1'b1;
            LOAD:    wr_en_c   = bus.wbyte_valid_i;
            RUN:     x_ready_c = 1'b1;
            default: ;
        endcase
        accept_c = bus.x_valid_i && x_ready_c;
        en_c     = accept_c || (state == DRAIN);
    end

    assign bus.wbyte_ready_o = (state == LOAD);
    assign bus.x_ready_o     = x_ready_c;
    assign bus.mult_en_o     = en_c;
    assign bus.mult_x_o      = (state == DRAIN) ? '0 : bus.x_i;
    assign bus.mult_rst_n_o  = !(rst || (state == CLEAR));
    assign bus.mult_w_o      = w;
    assign bus.w_loaded_o    = loaded;
    assign bus.w_err_o       = err;
    assign bus.busy_o        = (state != IDLE);

    // Results of the previous vector appear on mult_y_i in element order, one per enabled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase         <= '0;
            pending       <= 1'b0;
            bus.y_o       <= '0;
            bus.y_valid_o <= 1'b0;
            bus.y_idx_o   <= '0;
            bus.y_last_o  <= 1'b0;
        end else begin
            bus.y_valid_o <= 1'b0;
            bus.y_last_o  <= 1'b0;
            if (clear_c) begin
                phase   <= '0;
                pending <= 1'b0;
            end else if (en_c) begin
                phase <= phase + PH_W'(1);
                if (pending) begin
                    bus.y_valid_o <= 1'b1;
                    bus.y_idx_o   <= phase;
                    bus.y_o       <= bus.mult_y_i;
                    bus.y_last_o  <= (state == DRAIN) && (phase == PH_LAST);
                end
                // Wrap in RUN arms output tagging; the end of DRAIN disarms it for the next batch.
                if (phase == PH_LAST) pending <= (state != DRAIN);
            end
        end
    end

endmodule

// File: tb/tb_ternary_mvm_ctrl.sv
// Directed bench for ternary_mvm_ctrl with a behavioural 16x8 ternary multiplier attached.
module tb_ternary_mvm_ctrl;

    logic clk;
    logic rst;
    int   nchk;
    int   nfail;

    ternary_mvm_ctrl_if #(.IN_LEN(16), .OUT_LEN(8), .BIT_WIDTH(8)) bus ();

    ternary_mvm_ctrl #(.IN_LEN(16), .OUT_LEN(8), .BIT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: accumulates two rows per enabled edge, publishes after the 8th.
    int               mcnt;
    int               acc [8];
    logic signed [7:0] mout [8];
    int               tsum;

    function automatic int wv(input int n, input int j);
        logic [1:0] c;
        c = bus.mult_w_o[2*(n*8+j) +: 2];
        case (c)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!bus.mult_rst_n_o) begin
            mcnt <= 0;
            for (int j = 0; j < 8; j++) begin
                acc[j]  <= 0;
                mout[j] <= '0;
            end
        end else if (bus.mult_en_o) begin
            for (int j = 0; j < 8; j++) begin
                tsum = acc[j]
                     + wv(2*mcnt, j)   * int'($signed(bus.mult_x_o[7:0]))
                     + wv(2*mcnt+1, j) * int'($signed(bus.mult_x_o[15:8]));
                if (mcnt == 7) begin
                    mout[j] <= 8'(tsum);
                    acc[j]  <= 0;
                end else begin
                    acc[j] <= tsum;
                end
            end
            mcnt <= (mcnt == 7) ? 0 : mcnt + 1;
        end
    end

    assign bus.mult_y_i = mout[mcnt];

    // Strobe capture
    logic [7:0] ys[$];
    int         idxs[$];
    bit         lasts[$];

    always @(negedge clk) begin
        if (bus.y_valid_o === 1'b1) begin
            ys.push_back(bus.y_o);
            idxs.push_back(int'(bus.y_idx_o));
            lasts.push_back(bus.y_last_o);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_bytes(input logic [7:0] fill, input int sk, input logic [7:0] sval);
        for (int k = 0; k < 32; k++) begin
            bus.wbyte_i       = (k == sk) ? sval : fill;
            bus.wbyte_valid_i = 1'b1;
            if (k == 0) begin
                #1;
                check("wbyte_ready_in_load", 64'(bus.wbyte_ready_o), 64'd1);
            end
            cyc();
        end
        bus.wbyte_valid_i = 1'b0;
        check("w_loaded_after_load", 64'(bus.w_loaded_o), 64'd1);
        check("idle_after_load", 64'(bus.busy_o), 64'd0);
    endtask

    task automatic load_weights(input logic [7:0] fill, input int sk, input logic [7:0] sval);
        bus.load_i = 1'b1;
        cyc();
        bus.load_i = 1'b0;
        cyc();
        feed_bytes(fill, sk, sval);
    endtask

    // Sends np pairs, element e = base + inc*e; optional bubble after every pair.
    task automatic send_pairs(input int base, input int inc, input int np, input bit last, input bit bubble);
        for (int p = 0; p < np; p++) begin
            bus.x_i       = {8'(base + inc*(2*p+1)), 8'(base + inc*(2*p))};
            bus.x_valid_i = 1'b1;
            bus.x_last_i  = last && (p == np - 1);
            #1;
            check("x_ready_pair", 64'(bus.x_ready_o), 64'd1);
            check("mult_en_pair", 64'(bus.mult_en_o), 64'd1);
            cyc();
            if (bubble && !(last && p == np - 1)) begin
                bus.x_valid_i = 1'b0;
                bus.x_last_i  = 1'b0;
                #1;
                check("mult_en_bubble", 64'(bus.mult_en_o), 64'd0);
                check("x_ready_bubble", 64'(bus.x_ready_o), 64'd1);
                cyc();
            end
        end
        bus.x_valid_i = 1'b0;
        bus.x_last_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy_o === 1'b1 && n < 64) begin
            cyc();
            n++;
        end
        check("drain_timeout", 64'(bus.busy_o), 64'd0);
        cyc();
        cyc();
    endtask

    // n strobes: first 8 carry v1, rest v2; idx cycles 0..7; last only on the final one if expected.
    task automatic expect_batch(input int n, input logic [7:0] v1, input logic [7:0] v2, input bit last_end);
        check("strobe_count", 64'(ys.size()), 64'(n));
        for (int i = 0; i < n && i < ys.size(); i++) begin
            check($sformatf("y_val[%0d]", i), 64'(ys[i]), 64'((i < 8) ? v1 : v2));
            check($sformatf("y_idx[%0d]", i), 64'(idxs[i]), 64'(i % 8));
            check($sformatf("y_last[%0d]", i), 64'(lasts[i]), 64'(last_end && (i == n - 1)));
        end
        ys.delete();
        idxs.delete();
        lasts.delete();
    endtask

    initial begin
        nchk  = 0;
        nfail = 0;
        rst               = 1'b1;
        bus.load_i        = 1'b0;
        bus.wbyte_i       = '0;
        bus.wbyte_valid_i = 1'b0;
        bus.x_i           = '0;
        bus.x_valid_i     = 1'b0;
        bus.x_last_i      = 1'b0;

        // Reset state
        cyc();
        cyc();
        check("rst_mult_rst_n", 64'(bus.mult_rst_n_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_w_loaded", 64'(bus.w_loaded_o), 64'd0);
        check("rst_w_err", 64'(bus.w_err_o), 64'd0);
        check("rst_y_valid", 64'(bus.y_valid_o), 64'd0);
        check("rst_y_idx", 64'(bus.y_idx_o), 64'd0);
        check("rst_y_last", 64'(bus.y_last_o), 64'd0);
        check("rst_wbyte_ready", 64'(bus.wbyte_ready_o), 64'd0);
        check("rst_w_lo", bus.mult_w_o[63:0], 64'd0);
        rst = 1'b0;
        bus.x_valid_i = 1'b1;
        #1;
        check("unloaded_x_ready", 64'(bus.x_ready_o), 64'd0);
        cyc();
        bus.x_valid_i = 1'b0;
        check("post_rst_mult_rst_n", 64'(bus.mult_rst_n_o), 64'd1);
        check("unloaded_stays_idle", 64'(bus.busy_o), 64'd0);

        // All +1 weights, one vector 1..16: every output 136 -> 0x88
        load_weights(8'h55, -1, 8'h00);
        check("w_all_pos", bus.mult_w_o[63:0], 64'h5555_5555_5555_5555);
        check("w_err_clean", 64'(bus.w_err_o), 64'd0);
        send_pairs(1, 1, 8, 1'b1, 1'b0);
        wait_idle();
        expect_batch(8, 8'h88, 8'h88, 1'b1);

        // All -1 with an illegal-code byte at position 3
        load_weights(8'hFF, 3, 8'h99);
        check("w_err_set", 64'(bus.w_err_o), 64'd1);
        check("w_byte3_sanitized", 64'(bus.mult_w_o[31:24]), 64'h11);
        check("w_low_bytes", 64'(bus.mult_w_o[23:0]), 64'hFF_FFFF);
        check("w_top_byte", 64'(bus.mult_w_o[255:248]), 64'hFF);

        // Back-to-back vectors of 1s then 2s on +1 weights
        load_weights(8'h55, -1, 8'h00);
        check("w_err_cleared", 64'(bus.w_err_o), 64'd0);
        send_pairs(1, 0, 8, 1'b0, 1'b0);
        send_pairs(2, 0, 8, 1'b1, 1'b0);
        wait_idle();
        expect_batch(16, 8'h10, 8'h20, 1'b1);

        // Bubble every other cycle: same results as without bubbles
        send_pairs(1, 1, 8, 1'b1, 1'b1);
        wait_idle();
        expect_batch(8, 8'h88, 8'h88, 1'b1);

        // Load request and input pair together in IDLE
        bus.load_i    = 1'b1;
        bus.x_valid_i = 1'b1;
        bus.x_i       = 16'h0101;
        #1;
        check("both_x_ready", 64'(bus.x_ready_o), 64'd0);
        check("both_mult_en", 64'(bus.mult_en_o), 64'd0);
        check("both_mult_rst_n_idle", 64'(bus.mult_rst_n_o), 64'd1);
        cyc();
        bus.load_i    = 1'b0;
        bus.x_valid_i = 1'b0;
        #1;
        check("clear_mult_rst_n", 64'(bus.mult_rst_n_o), 64'd0);
        check("clear_busy", 64'(bus.busy_o), 64'd1);
        check("clear_x_ready", 64'(bus.x_ready_o), 64'd0);
        cyc();
        check("load_mult_rst_n", 64'(bus.mult_rst_n_o), 64'd1);
        check("load_w_loaded_cleared", 64'(bus.w_loaded_o), 64'd0);
        feed_bytes(8'h55, -1, 8'h00);
        check("no_strobes_from_load", 64'(ys.size()), 64'd0);

        // Reset in RUN at phase 3 with results in flight
        send_pairs(1, 0, 8, 1'b0, 1'b0);
        send_pairs(2, 0, 3, 1'b0, 1'b0);
        bus.x_valid_i = 1'b1;
        bus.x_i       = 16'h0202;
        rst           = 1'b1;
        cyc();
        check("midrun_rst_busy", 64'(bus.busy_o), 64'd0);
        check("midrun_rst_w_loaded", 64'(bus.w_loaded_o), 64'd0);
        check("midrun_rst_w_zero", bus.mult_w_o[63:0], 64'd0);
        check("midrun_rst_y_valid", 64'(bus.y_valid_o), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) cyc();
        check("post_rst_x_ready", 64'(bus.x_ready_o), 64'd0);
        check("post_rst_idle", 64'(bus.busy_o), 64'd0);
        bus.x_valid_i = 1'b0;
        expect_batch(3, 8'h10, 8'h10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
